// File: rtl/byte_pack_pkg.sv
// Shared constants and helpers for the byte-to-word packing datapath.
package byte_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int DROP_W = 16;

  // Saturating increment for the dropped-word counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pack_word_fifo.sv
// Synchronous FIFO for packed words; the head is presented directly and reads 0 when empty.
module pack_word_fifo
  import byte_pack_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, and an unreset array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into OUT_BYTES-wide words with byte enables,
// buffered in a small FIFO; words that find the FIFO full are dropped and counted.
module byte_word_packer
  import byte_pack_pkg::*;
#(
  parameter int OUT_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           data_in,
  input  logic                        valid,
  input  logic                        flush,
  output logic [BYTE_W*OUT_BYTES-1:0] word_out,
  output logic [OUT_BYTES-1:0]        word_be,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_count
);

  localparam int WORD_W = BYTE_W * OUT_BYTES;
  localparam int IDX_W  = $clog2(OUT_BYTES);

  typedef struct packed {
    logic [WORD_W-1:0]    data;
    logic [OUT_BYTES-1:0] be;
  } packed_word_t;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [WORD_W-1:0] asm_data;
  logic [WORD_W-1:0] asm_next;
  logic              push_req;
  packed_word_t      push_word;
  packed_word_t      head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;
  int                fill;

  // NOTE: every combinational output gets a default first so no path can
  // leave one unassigned and infer a latch; blocking '=' is used here only.
  always_comb begin
    idx_next  = idx;
    asm_next  = asm_data;
    push_req  = 1'b0;
    push_word = '0;
    fill      = int'(idx);

    if (valid) begin
      asm_next[fill*BYTE_W +: BYTE_W] = data_in;
      fill = fill + 1;
    end

    if (fill == OUT_BYTES) begin
      push_req       = 1'b1;
      push_word.data = asm_next;
      push_word.be   = '1;
      idx_next       = '0;
      asm_next       = '0;
    end else if (flush && fill > 0) begin
      // Lanes not yet written are still zero because the register clears on every push.
      push_req       = 1'b1;
      push_word.data = asm_next;
      for (int i = 0; i < OUT_BYTES; i++) push_word.be[i] = (i < fill);
      idx_next       = '0;
      asm_next       = '0;
    end else if (valid) begin
      idx_next = IDX_W'(fill);
    end
  end

  assign pop  = word_valid && word_ready;
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      asm_data   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      idx      <= idx_next;
      asm_data <= asm_next;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  pack_word_fifo #(
    .WIDTH ($bits(packed_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_word),
    .full      (fifo_full),
    .pop       (pop),
    .head      (head_word),
    .empty     (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign word_out   = head_word.data;
  assign word_be    = head_word.be;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: stimulus pushes hand-computed words into a
// scoreboard queue and an independent monitor compares every accepted output word.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } exp_word_t;

  exp_word_t sb_q[$];

  byte_word_packer #(.OUT_BYTES(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid      (valid),
    .flush      (flush),
    .word_out   (word_out),
    .word_be    (word_be),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] be);
    exp_word_t w;
    w.data = d;
    w.be   = be;
    sb_q.push_back(w);
  endtask

  // One clock with the given byte-side inputs; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic f);
    valid   = v;
    data_in = d;
    flush   = f;
    @(posedge clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
  endtask

  // Monitor: inputs change just after posedge, so the negedge value predicts the handshake.
  initial begin
    exp_word_t w;
    forever begin
      @(negedge clk);
      if (!rst && word_valid && word_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", {28'h0, word_be, word_out}, 64'h0);
        end else begin
          w = sb_q.pop_front();
          check("word_data", 64'(word_out), 64'(w.data));
          check("word_be",   64'(word_be),  64'(w.be));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_word_valid", 64'(word_valid), 64'h0);
    check("rst_word_out",   64'(word_out),   64'h0);
    check("rst_word_be",    64'(word_be),    64'h0);
    check("rst_overflow",   64'(overflow),   64'h0);
    check("rst_drop_count", 64'(drop_count), 64'h0);

    // 1: two full words, each visible one cycle after its fourth byte
    word_ready = 1'b1;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 4 || i == 8) begin
        check("t1_latency_valid", 64'(word_valid), 64'h1);
        check("t1_latency_data", 64'(word_out), (i == 4) ? 64'h04030201 : 64'h08070605);
      end
    end
    step(1'b0, 8'h00, 1'b0);

    // 2: partial word via flush, then a flush with nothing pending
    expect_word(32'h00CCBBAA, 4'h7);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("t2_partial_be", 64'(word_be), 64'h7);
    step(1'b0, 8'h00, 1'b1);
    check("t2_empty_flush", 64'(word_valid), 64'h0);

    // 3: completing byte in the flush cycle yields exactly one full word
    expect_word(32'hDD332211, 4'hF);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'hDD, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("t3_no_extra_word", 64'(word_valid), 64'h0);

    // 4: stall consumer, send six words; last two are dropped
    word_ready = 1'b0;
    expect_word(32'h13121110, 4'hF);
    expect_word(32'h17161514, 4'hF);
    expect_word(32'h1B1A1918, 4'hF);
    expect_word(32'h1F1E1D1C, 4'hF);
    for (int i = 0; i < 24; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    check("t4_overflow",   64'(overflow),   64'h1);
    check("t4_drop_count", 64'(drop_count), 64'h2);
    check("t4_head_held",  64'(word_out),   64'h13121110);

    // 5: full FIFO, push and pop together -> no drop
    expect_word(32'h33323130, 4'hF);
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    word_ready = 1'b1;
    step(1'b1, 8'h33, 1'b0);
    word_ready = 1'b0;
    check("t5_drop_count", 64'(drop_count), 64'h2);
    check("t5_head_next",  64'(word_out),   64'h17161514);
    word_ready = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b0);
    check("t5_drained_after_4", 64'(word_valid), 64'h0);

    // 6: reset with queued words and a partial word discards everything
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h50, 1'b0);
    step(1'b1, 8'h51, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h99, 1'b0);
    rst = 1'b0;
    check("t6_word_valid", 64'(word_valid), 64'h0);
    check("t6_word_out",   64'(word_out),   64'h0);
    check("t6_word_be",    64'(word_be),    64'h0);
    check("t6_overflow",   64'(overflow),   64'h0);
    check("t6_drop_count", 64'(drop_count), 64'h0);
    word_ready = 1'b1;
    expect_word(32'h63626160, 4'hF);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0);

    // Bounded drain of anything still expected
    begin
      int budget = 50;
      while (sb_q.size() != 0 && budget > 0) begin
        step(1'b0, 8'h00, 1'b0);
        budget--;
      end
      check("final_scoreboard_empty", 64'(sb_q.size()), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
